lsu_wb_stage: RTL
=================

Name: lsu_wb_stage

Overview:
- Memory/writeback stage of the RV32I pipeline. It accepts one instruction per handshake from the execute stage.
- Load/store accesses go to data memory over a req/ack handshake. Loads are aligned and sign/zero-extended.
- The stage drives the register file write port (rd addr/wen/data).
- It stalls upstream while a memory access is outstanding. Misaligned, illegal and timed-out accesses are reported as faults.

Parameters:
- REGIDX_WIDTH, 5, register index width; matches the register file.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for i_dmem_ack before abort (1..255).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; transfer occurs when i_valid & o_ready.
- i_is_load  in  1  instruction is a load.
- i_is_store  in  1  instruction is a store.
- i_funct3  in  3  RV32I width/sign code.
- i_addr  in  32  effective byte address.
- i_store_data  in  32  rs2 value.
- i_alu_result  in  32  writeback value for non-memory ops.
- i_rd_addr  in  REGIDX_WIDTH  destination register.
- i_rd_wen  in  1  instruction writes rd.
- o_dmem_req  out  1  memory request, held until ack.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  32  word address; bits [1:0] forced to 0.
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_bmask  out  4  byte enables; meaningful for stores only.
- i_dmem_ack  in  1  one-cycle completion; rdata valid with it.
- i_dmem_rdata  in  32  load word.
- o_rd_addr  out  REGIDX_WIDTH  to register file write port.
- o_rd_wen  out  1  register file write enable.
- o_rd_data  out  32  register file write data.
- o_fault  out  1  one-cycle fault pulse.
- o_fault_cause  out  2  01 misaligned, 10 illegal, 11 timeout; valid with o_fault.

Behaviour:
- Reset:
  - Async, active-low. State goes to IDLE, timeout counter to 0.
  - o_dmem_req, o_dmem_we, o_rd_wen and o_fault go to 0. All data/address outputs go to 0.
  - o_ready is 0 while i_rst_n is low and 1 in IDLE afterwards.
  - Reset mid-access drops the access: req falls asynchronously and no writeback occurs.
- FSM is IDLE / BUSY. o_ready = (state==IDLE) & i_rst_n.
- IDLE accept, non-memory op:
  - The next cycle pulses o_rd_wen = i_rd_wen & (i_rd_addr!=0), with o_rd_data = i_alu_result. Latency is 1.
  - The stage stays in IDLE and can accept every cycle.
- IDLE accept, legality checks (first match wins):
  - is_load & is_store, or load funct3 in {011,110,111}, or store funct3 not in {000,001,010}: fault cause 10.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0: fault cause 01.
  - A fault pulses o_fault the next cycle, with no memory access and no writeback. State stays IDLE.
- IDLE accept, legal memory op:
  - The next cycle enters BUSY with o_dmem_req=1.
  - Address, we, wdata and bmask are registered at accept and held stable until ack.
  - Store SB: bmask = 0001 << addr[1:0], wdata = byte replicated x4.
  - Store SH: bmask = 0011 if addr[1]=0, else 1100; wdata = half replicated x2.
  - Store SW: bmask = 1111.
  - Loads: bmask = 0000.
- BUSY:
  - o_ready=0 and the counter increments each cycle.
  - On i_dmem_ack, req drops next cycle and state returns to IDLE; o_ready=1 in that cycle.
  - Load on ack: the next cycle pulses o_rd_wen (suppressed if rd=0). o_rd_data is the selected lane of rdata, per the captured addr[1:0].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Store on ack: no writeback.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES with no ack, req drops and state returns to IDLE.
  - o_fault pulses with cause 11, with no writeback.
  - An ack in the same cycle as expiry wins over the timeout.
- Spurious ack: i_dmem_ack in IDLE is ignored.
- Write-port outputs:
  - o_rd_addr/o_rd_data change only with a writeback pulse and hold otherwise.
  - o_rd_wen is never high for more than one cycle per instruction.
  - o_fault and o_rd_wen are never both high.

Test Plan:
- Non-memory op: accept alu_result=0x1234_5678, rd=5, rd_wen=1 -> next cycle o_rd_wen=1, o_rd_addr=5, o_rd_data=0x1234_5678. Same op with rd=0 -> o_rd_wen stays 0.
- LB at addr 0x103, rdata=0x80FF_0000, ack after 3 BUSY cycles -> o_ready=0 during the wait, o_dmem_addr=0x100, then o_rd_data=0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH at 0x202, store_data=0x0000_ABCD -> o_dmem_we=1, addr=0x200, bmask=1100, wdata=0xABCD_ABCD, and no writeback after ack.
- LW at 0x101 -> o_fault=1, cause 01, no o_dmem_req. Load funct3=011 at 0x100 -> o_fault=1, cause 10.
- TIMEOUT_CYCLES=4 with no ack -> req is high for exactly 4 cycles, then o_fault=1 with cause 11, back to IDLE, and the next instruction is accepted.
- Assert i_rst_n=0 two cycles into a load's BUSY phase -> o_dmem_req=0 immediately. After release: no writeback, and o_ready=1.

Source files
------------

// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: RV32I memory/writeback stage.
// Accepts one instruction per valid/ready handshake. Non-memory ops write back
// one cycle later. Legal loads/stores go to data memory over a req/ack
// handshake, during which the stage stalls upstream. Illegal encodings,
// misaligned addresses and memory timeouts raise a one-cycle fault pulse.
module lsu_wb_stage #(
  parameter int REGIDX_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_is_load,
  input  logic                    i_is_store,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_store_data,
  input  logic [31:0]             i_alu_result,
  input  logic [REGIDX_WIDTH-1:0] i_rd_addr,
  input  logic                    i_rd_wen,
  output logic                    o_dmem_req,
  output logic                    o_dmem_we,
  output logic [31:0]             o_dmem_addr,
  output logic [31:0]             o_dmem_wdata,
  output logic [3:0]              o_dmem_bmask,
  input  logic                    i_dmem_ack,
  input  logic [31:0]             i_dmem_rdata,
  output logic [REGIDX_WIDTH-1:0] o_rd_addr,
  output logic                    o_rd_wen,
  output logic [31:0]             o_rd_data,
  output logic                    o_fault,
  output logic [1:0]              o_fault_cause
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Counter value seen in the last BUSY cycle that may still accept an ack.
  localparam logic [7:0] CNT_LAST      = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // FSM and access-tracking state
  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic                    ld_reg, ld_next;
  logic [2:0]              f3_reg, f3_next;
  logic [1:0]              off_reg, off_next;
  logic [REGIDX_WIDTH-1:0] pend_rd_reg, pend_rd_next;
  logic                    pend_wen_reg, pend_wen_next;

  // Registered outputs
  logic                    req_reg, req_next;
  logic                    we_reg, we_next;
  logic [31:0]             addr_reg, addr_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic [3:0]              bmask_reg, bmask_next;
  logic [REGIDX_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic                    rd_wen_reg, rd_wen_next;
  logic [31:0]             rd_data_reg, rd_data_next;
  logic                    fault_reg, fault_next;
  logic [1:0]              cause_reg, cause_next;

  // Decode helpers
  logic        accept;
  logic        is_mem;
  logic        illegal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_bmask;
  logic [3:0]  sb_bmask;
  logic [7:0]  rdata_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign o_ready = (state_reg == ST_IDLE) & i_rst_n;
  assign accept  = i_valid & o_ready;

  // Per-lane views: read-data byte lanes and one-hot byte-store enables.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_lane[gi] = i_dmem_rdata[8*gi +: 8];
      assign sb_bmask[gi]   = (i_addr[1:0] == 2'(gi));
    end
  endgenerate

  // Legality checks and store lane formatting for the incoming instruction.
  always_comb begin
    is_mem  = i_is_load | i_is_store;
    illegal = 1'b0;
    if (i_is_load && i_is_store) begin
      illegal = 1'b1;
    end else if (i_is_load) begin
      illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    end else if (i_is_store) begin
      illegal = !((i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010));
    end
    misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    case (i_funct3[1:0])
      2'b00: begin
        st_wdata = {4{i_store_data[7:0]}};
        st_bmask = sb_bmask;
      end
      2'b01: begin
        st_wdata = {2{i_store_data[15:0]}};
        st_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = i_store_data;
        st_bmask = 4'b1111;
      end
    endcase
  end

  // Select and extend the load lane using the offset captured at accept.
  always_comb begin
    ld_byte = rdata_lane[off_reg];
    ld_half = off_reg[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (f3_reg)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = i_dmem_rdata;
    endcase
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ld_next       = ld_reg;
    f3_next       = f3_reg;
    off_next      = off_reg;
    pend_rd_next  = pend_rd_reg;
    pend_wen_next = pend_wen_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    bmask_next    = bmask_reg;
    rd_addr_next  = rd_addr_reg;
    rd_data_next  = rd_data_reg;
    rd_wen_next   = 1'b0;
    fault_next    = 1'b0;
    cause_next    = cause_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            if (i_rd_wen && (i_rd_addr != '0)) begin
              rd_wen_next  = 1'b1;
              rd_addr_next = i_rd_addr;
              rd_data_next = i_alu_result;
            end
          end else if (illegal) begin
            fault_next = 1'b1;
            cause_next = CAUSE_ILLEGAL;
          end else if (misaligned) begin
            fault_next = 1'b1;
            cause_next = CAUSE_MISALGN;
          end else begin
            state_next    = ST_BUSY;
            cnt_next      = 8'd0;
            req_next      = 1'b1;
            we_next       = i_is_store;
            addr_next     = {i_addr[31:2], 2'b00};
            wdata_next    = st_wdata;
            bmask_next    = i_is_store ? st_bmask : 4'b0000;
            ld_next       = i_is_load;
            f3_next       = i_funct3;
            off_next      = i_addr[1:0];
            pend_rd_next  = i_rd_addr;
            pend_wen_next = i_rd_wen;
          end
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg + 8'd1;
        if (i_dmem_ack) begin
          // Ack wins even when it lands on the expiry cycle.
          state_next = ST_IDLE;
          req_next   = 1'b0;
          if (ld_reg && pend_wen_reg && (pend_rd_reg != '0)) begin
            rd_wen_next  = 1'b1;
            rd_addr_next = pend_rd_reg;
            rd_data_next = ld_value;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
          fault_next = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 8'd0;
      ld_reg       <= 1'b0;
      f3_reg       <= 3'd0;
      off_reg      <= 2'd0;
      pend_rd_reg  <= '0;
      pend_wen_reg <= 1'b0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      bmask_reg    <= 4'd0;
      rd_addr_reg  <= '0;
      rd_wen_reg   <= 1'b0;
      rd_data_reg  <= 32'd0;
      fault_reg    <= 1'b0;
      cause_reg    <= 2'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ld_reg       <= ld_next;
      f3_reg       <= f3_next;
      off_reg      <= off_next;
      pend_rd_reg  <= pend_rd_next;
      pend_wen_reg <= pend_wen_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      bmask_reg    <= bmask_next;
      rd_addr_reg  <= rd_addr_next;
      rd_wen_reg   <= rd_wen_next;
      rd_data_reg  <= rd_data_next;
      fault_reg    <= fault_next;
      cause_reg    <= cause_next;
    end
  end

  assign o_dmem_req    = req_reg;
  assign o_dmem_we     = we_reg;
  assign o_dmem_addr   = addr_reg;
  assign o_dmem_wdata  = wdata_reg;
  assign o_dmem_bmask  = bmask_reg;
  assign o_rd_addr     = rd_addr_reg;
  assign o_rd_wen      = rd_wen_reg;
  assign o_rd_data     = rd_data_reg;
  assign o_fault       = fault_reg;
  assign o_fault_cause = cause_reg;

endmodule
